// File: rtl/writeback.sv
// Writeback stage: per-channel result FIFOs for the ALU and MEM units, merged by a
// round-robin arbiter into one registered register-file write port (res_v / ok_i).

module writeback_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array is not reset; an entry is only read while count_q marks it valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == FULL_COUNT);
    assign empty = (count_q == '0);
endmodule

module writeback #(
    parameter int xlen       = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_v,
    input  logic [4:0]      alu_rd,
    input  logic [xlen-1:0] alu_data,
    output logic            alu_ok_o,
    input  logic            mem_v,
    input  logic [4:0]      mem_rd,
    input  logic [xlen-1:0] mem_data,
    output logic            mem_ok_o,
    output logic            res_v,
    output logic [4:0]      res_adr,
    output logic [xlen-1:0] res_data,
    input  logic            ok_i
);
    localparam int EW = 5 + xlen;

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_MEM = 1'b1
    } grant_e;

    logic            alu_full, alu_empty, alu_push, alu_pop;
    logic            mem_full, mem_empty, mem_push, mem_pop;
    logic [EW-1:0]   alu_head, mem_head;
    logic            slot_free;

    logic            res_v_q, res_v_d;
    logic [4:0]      res_adr_q, res_adr_d;
    logic [xlen-1:0] res_data_q, res_data_d;
    grant_e          last_grant_q, last_grant_d;

    // Acceptance looks only at the registered count; rd == 0 completes the handshake but is dropped.
    assign alu_ok_o = !alu_full;
    assign mem_ok_o = !mem_full;
    assign alu_push = alu_v && alu_ok_o && (alu_rd != 5'd0);
    assign mem_push = mem_v && mem_ok_o && (mem_rd != 5'd0);
    assign slot_free = !res_v_q || ok_i;

    writeback_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (alu_push),
        .pop   (alu_pop),
        .wdata ({alu_rd, alu_data}),
        .rdata (alu_head),
        .full  (alu_full),
        .empty (alu_empty)
    );

    writeback_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_mem_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (mem_push),
        .pop   (mem_pop),
        .wdata ({mem_rd, mem_data}),
        .rdata (mem_head),
        .full  (mem_full),
        .empty (mem_empty)
    );

    // On a tie the channel not granted last time wins; a lone non-empty channel always wins.
    always_comb begin
        res_v_d      = res_v_q;
        res_adr_d    = res_adr_q;
        res_data_d   = res_data_q;
        last_grant_d = last_grant_q;
        alu_pop      = 1'b0;
        mem_pop      = 1'b0;
        if (slot_free) begin
            if (!alu_empty && (mem_empty || last_grant_q == GRANT_MEM)) begin
                alu_pop                 = 1'b1;
                res_v_d                 = 1'b1;
                {res_adr_d, res_data_d} = alu_head;
                last_grant_d            = GRANT_ALU;
            end else if (!mem_empty) begin
                mem_pop                 = 1'b1;
                res_v_d                 = 1'b1;
                {res_adr_d, res_data_d} = mem_head;
                last_grant_d            = GRANT_MEM;
            end else begin
                res_v_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_v_q      <= 1'b0;
            res_adr_q    <= '0;
            res_data_q   <= '0;
            last_grant_q <= GRANT_ALU;
        end else begin
            res_v_q      <= res_v_d;
            res_adr_q    <= res_adr_d;
            res_data_q   <= res_data_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign res_v    = res_v_q;
    assign res_adr  = res_adr_q;
    assign res_data = res_data_q;
endmodule

// File: tb/tb_writeback.sv
// Bench for writeback: directed scenarios plus randomized traffic, checked by a
// queue-based reference model feeding a scoreboard that a negedge monitor drains.

module tb_writeback;
    localparam int XLEN  = 32;
    localparam int DEPTH = 2;

    typedef logic [36:0] ent_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            alu_v, mem_v, ok_i;
    logic [4:0]      alu_rd, mem_rd;
    logic [XLEN-1:0] alu_data, mem_data;
    logic            alu_ok_o, mem_ok_o;
    logic            res_v;
    logic [4:0]      res_adr;
    logic [XLEN-1:0] res_data;

    int n_checks = 0;
    int n_fail   = 0;

    writeback #(.xlen(XLEN), .FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .alu_v    (alu_v),
        .alu_rd   (alu_rd),
        .alu_data (alu_data),
        .alu_ok_o (alu_ok_o),
        .mem_v    (mem_v),
        .mem_rd   (mem_rd),
        .mem_data (mem_data),
        .mem_ok_o (mem_ok_o),
        .res_v    (res_v),
        .res_adr  (res_adr),
        .res_data (res_data),
        .ok_i     (ok_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each channel is a queue of {rd, data}; the output slot is one entry.
    ent_t alu_q[$];
    ent_t mem_q[$];
    ent_t exp_q[$];
    bit   m_res_v;
    bit   m_last_mem;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_q.delete();
            mem_q.delete();
            exp_q.delete();
            m_res_v    = 1'b0;
            m_last_mem = 1'b0;
        end else begin
            bit   a_acc, m_acc, a_has, m_has, pick_mem;
            ent_t e;
            a_acc = alu_v && (alu_q.size() < DEPTH);
            m_acc = mem_v && (mem_q.size() < DEPTH);
            a_has = alu_q.size() != 0;
            m_has = mem_q.size() != 0;
            if (!m_res_v || ok_i) begin
                if (a_has || m_has) begin
                    pick_mem = m_has && (!a_has || !m_last_mem);
                    if (pick_mem) e = mem_q.pop_front();
                    else          e = alu_q.pop_front();
                    m_last_mem = pick_mem;
                    m_res_v    = 1'b1;
                    exp_q.push_back(e);
                end else begin
                    m_res_v = 1'b0;
                end
            end
            if (a_acc && alu_rd != 5'd0) alu_q.push_back({alu_rd, alu_data});
            if (m_acc && mem_rd != 5'd0) mem_q.push_back({mem_rd, mem_data});
        end
    end

    // Monitor: mid-cycle compare of flow control, stall stability and accepted writes.
    bit              prev_stall = 1'b0;
    logic [4:0]      prev_adr;
    logic [XLEN-1:0] prev_data;

    always @(negedge clk) begin
        ent_t e;
        check("res_v_vs_model", res_v, m_res_v);
        check("alu_ok_vs_model", alu_ok_o, alu_q.size() < DEPTH);
        check("mem_ok_vs_model", mem_ok_o, mem_q.size() < DEPTH);
        if (rst_n && prev_stall) begin
            check("stall_hold_v", res_v, 1'b1);
            check("stall_hold_adr", res_adr, prev_adr);
            check("stall_hold_data", res_data, prev_data);
        end
        if (rst_n && res_v && ok_i) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 1'b1, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("write_adr", res_adr, e[36:32]);
                check("write_data", res_data, e[31:0]);
            end
        end
        prev_stall = rst_n && res_v && !ok_i;
        prev_adr   = res_adr;
        prev_data  = res_data;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        alu_v = 1'b0;
        mem_v = 1'b0;
        ok_i  = 1'b1;
        repeat (n) cyc();
    endtask

    task automatic expect_out(input string name, input logic v, input logic [4:0] adr,
                              input logic [31:0] data);
        check({name, "_v"}, res_v, v);
        if (v) begin
            check({name, "_adr"}, res_adr, adr);
            check({name, "_data"}, res_data, data);
        end
    endtask

    int pv[3]  = '{50, 85, 30};
    int pok[3] = '{90, 40, 100};

    initial begin
        rst_n    = 1'b0;
        alu_v    = 1'b0;
        mem_v    = 1'b0;
        alu_rd   = '0;
        mem_rd   = '0;
        alu_data = '0;
        mem_data = '0;
        ok_i     = 1'b1;
        #2;
        check("rst_res_v", res_v, 1'b0);
        check("rst_res_adr", res_adr, 5'd0);
        check("rst_res_data", res_data, 32'd0);
        check("rst_alu_ok", alu_ok_o, 1'b1);
        check("rst_mem_ok", mem_ok_o, 1'b1);
        #10 rst_n = 1'b1;
        cyc();

        // Tie right after reset: MEM first, then ALU.
        alu_v = 1'b1; alu_rd = 5'd1; alu_data = 32'h11;
        mem_v = 1'b1; mem_rd = 5'd2; mem_data = 32'h22;
        cyc();
        alu_v = 1'b0; mem_v = 1'b0;
        cyc();
        expect_out("tie_first", 1'b1, 5'd2, 32'h22);
        cyc();
        expect_out("tie_second", 1'b1, 5'd1, 32'h11);
        idle(3);

        // Single ALU write: visible exactly two edges after acceptance, for one cycle.
        alu_v = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        cyc();
        alu_v = 1'b0;
        expect_out("single_n0", 1'b0, 5'd0, 32'd0);
        cyc();
        expect_out("single_n1", 1'b1, 5'd5, 32'hDEADBEEF);
        cyc();
        expect_out("single_n2", 1'b0, 5'd0, 32'd0);
        idle(2);

        // Backpressure: three stalled cycles, queued rd=4 follows with no bubble.
        ok_i = 1'b0;
        alu_v = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
        cyc();
        alu_rd = 5'd4; alu_data = 32'h44;
        cyc();
        alu_v = 1'b0;
        repeat (3) begin
            expect_out("bp_hold", 1'b1, 5'd3, 32'h33);
            cyc();
        end
        expect_out("bp_hold_last", 1'b1, 5'd3, 32'h33);
        ok_i = 1'b1;
        cyc();
        expect_out("bp_next", 1'b1, 5'd4, 32'h44);
        cyc();
        expect_out("bp_done", 1'b0, 5'd0, 32'd0);
        idle(2);

        // Fill the ALU FIFO under stall, then drain in order 7, 8, 9, 10.
        ok_i = 1'b0;
        alu_v = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
        cyc();
        alu_rd = 5'd8; alu_data = 32'h88;
        cyc();
        expect_out("fill_slot7", 1'b1, 5'd7, 32'h77);
        alu_rd = 5'd9; alu_data = 32'h99;
        cyc();
        check("fill_full", alu_ok_o, 1'b0);
        alu_rd = 5'd10; alu_data = 32'hAA;
        cyc();
        check("fill_held_off", alu_ok_o, 1'b0);
        cyc();
        check("fill_still_full", alu_ok_o, 1'b0);
        ok_i = 1'b1;
        cyc();
        expect_out("fill_out8", 1'b1, 5'd8, 32'h88);
        check("fill_ok_back", alu_ok_o, 1'b1);
        cyc();
        alu_v = 1'b0;
        expect_out("fill_out9", 1'b1, 5'd9, 32'h99);
        cyc();
        expect_out("fill_out10", 1'b1, 5'd10, 32'hAA);
        cyc();
        expect_out("fill_done", 1'b0, 5'd0, 32'd0);
        idle(2);

        // rd == 0 is accepted and dropped; the MEM FIFO never fills.
        ok_i = 1'b0;
        mem_v = 1'b1; mem_rd = 5'd0; mem_data = 32'hFFFFFFFF;
        repeat (3) begin
            check("rd0_mem_ok", mem_ok_o, 1'b1);
            cyc();
        end
        mem_v = 1'b0;
        repeat (3) begin
            check("rd0_mem_ok_after", mem_ok_o, 1'b1);
            check("rd0_no_write", res_v, 1'b0);
            cyc();
        end
        idle(2);

        // Reset mid-operation with both FIFOs full and a write pending.
        ok_i = 1'b0;
        repeat (4) begin
            alu_v = 1'b1; alu_rd = 5'($urandom_range(1, 31)); alu_data = $urandom;
            mem_v = 1'b1; mem_rd = 5'($urandom_range(1, 31)); mem_data = $urandom;
            cyc();
        end
        alu_v = 1'b0; mem_v = 1'b0;
        check("midrst_pre_v", res_v, 1'b1);
        check("midrst_pre_alu_full", alu_ok_o, 1'b0);
        check("midrst_pre_mem_full", mem_ok_o, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_v_async", res_v, 1'b0);
        check("midrst_adr", res_adr, 5'd0);
        check("midrst_alu_ok", alu_ok_o, 1'b1);
        check("midrst_mem_ok", mem_ok_o, 1'b1);
        #17 rst_n = 1'b1;
        ok_i = 1'b1;
        cyc();
        repeat (5) begin
            check("midrst_no_stale", res_v, 1'b0);
            check("midrst_alu_ok_after", alu_ok_o, 1'b1);
            check("midrst_mem_ok_after", mem_ok_o, 1'b1);
            cyc();
        end

        // Randomized traffic across load and backpressure mixes.
        for (int ph = 0; ph < 3; ph++) begin
            for (int i = 0; i < 800; i++) begin
                alu_v    = ($urandom_range(0, 99) < pv[ph]);
                alu_rd   = 5'($urandom_range(0, 31));
                alu_data = $urandom;
                mem_v    = ($urandom_range(0, 99) < pv[ph]);
                mem_rd   = 5'($urandom_range(0, 31));
                mem_data = $urandom;
                ok_i     = ($urandom_range(0, 99) < pok[ph]);
                cyc();
            end
        end
        idle(10);
        check("drain_scoreboard_empty", exp_q.size(), 0);
        check("drain_res_v", res_v, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/writeback.md
# writeback

Writeback stage of the CPU pipeline. Sits directly downstream of the `alu` and `mem` execution units and upstream of the `register_manager` result port (`res_v`/`res_adr`/`res_data`/`ok_i`). Each unit has a small per-channel FIFO, so neither unit stalls on a single-port register-file conflict. A round-robin arbiter merges the two result streams into one registered write port with valid/ok backpressure.

## Interface
- `xlen`, 32, data width.
- `FIFO_DEPTH`, 2, entries per channel FIFO; power of two, ≥2.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `alu_v`  in  1  ALU result valid.
- `alu_rd`  in  5  ALU destination register.
- `alu_data`  in  xlen  ALU result.
- `alu_ok_o`  out  1  ALU channel can accept this cycle.
- `mem_v`  in  1  load result valid.
- `mem_rd`  in  5  load destination register.
- `mem_data`  in  xlen  load result, already extended.
- `mem_ok_o`  out  1  MEM channel can accept this cycle.
- `res_v`  out  1  register write request.
- `res_adr`  out  5  register index.
- `res_data`  out  xlen  write data.
- `ok_i`  in  1  `register_manager` accepts the current write.

## Operation
- **Enqueue.** A channel transfer occurs on an edge where `x_v && x_ok_o`. Entry {rd, data} is pushed into that channel's FIFO.
- **x_ok_o.** `x_ok_o = (count_x != FIFO_DEPTH)`. It depends only on the registered count, never on same-cycle pops. A full FIFO refuses input even if it pops in that cycle.
- **rd == 0.** The transfer is accepted (handshake completes) but nothing is pushed. Count is unchanged and no write is ever issued.
- **Order.** FIFO order is preserved within a channel. Cross-channel ordering and same-rd hazards are not handled here; issue logic guarantees them.
- **Output slot.** The output is a single register {`res_v`, `res_adr`, `res_data`}. The slot is free when `!res_v || ok_i`.
- **Arbitration.** Runs when the slot is free.
  - Neither FIFO non-empty: `res_v` ← 0.
  - Exactly one FIFO non-empty: pop its head into the slot.
  - Both non-empty: grant the channel opposite `last_grant`, then update `last_grant`.
- **Stall.** While `res_v && !ok_i`, the outputs hold stable and no pop occurs.
- **last_grant.** Resets to ALU, so MEM wins the first tie.
- **FIFO implementation.** Each FIFO uses rd/wr pointers of log2(FIFO_DEPTH) bits that wrap modulo depth, plus a count of log2(FIFO_DEPTH)+1 bits.
  - Push only: count +1. Pop only: count −1. Push and pop in the same cycle: count unchanged.
  - Push and pop on the same cycle when count = 1 are legal.

## Timing
- **Reset values.** `res_v`=0, `res_adr`=0, `res_data`=0. All counts and pointers are 0, `last_grant`=ALU. `alu_ok_o`=`mem_ok_o`=1 throughout reset and after release.
- **Reset mid-operation.** Reset asserted at any time empties both FIFOs and drops `res_v` asynchronously. Buffered results are discarded.
- **Minimum latency.** 2 cycles. An input accepted at edge N is in the FIFO during N+1 and pops at edge N+1, so `res_v` is high in cycle N+2 (between edges N+1 and N+2).
- **Throughput.** One write per cycle with `ok_i` held high.
  - Both channels streaming: writes alternate ALU/MEM.
  - Each channel sustains 1/2 rate without its FIFO filling.
- **Refill after stall.** When `ok_i` rises with `res_v` high, the next entry (if any) appears the following cycle. There is no bubble.
- **Simultaneous inputs.** Both channels may enqueue in the same cycle. This is independent of output state.

## Test plan
- **Single ALU write.** `alu_v`=1, rd=5, data=0xDEADBEEF for one cycle, `ok_i`=1 → `res_v`=1, `res_adr`=5, `res_data`=0xDEADBEEF exactly 2 cycles later, for one cycle only.
- **Simultaneous inputs, tie after reset.** ALU (rd=1, 0x11) and MEM (rd=2, 0x22) in the same cycle, `ok_i`=1 → writes rd=2 then rd=1 on consecutive cycles.
- **Backpressure.** `ok_i`=0 for 3 cycles while `res_v`=1 (rd=3, 0x33), with a second ALU entry (rd=4) queued → outputs stable for all 3 cycles. rd=4 appears the cycle after `ok_i` returns to 1.
- **Fill FIFO.** `ok_i`=0, push 3 ALU entries (rd=7,8,9).
  - rd=7 moves to the output; rd=8 and rd=9 fill the FIFO, so `alu_ok_o`=0.
  - rd=10 is held off until a pop.
  - Release `ok_i` → order 7, 8, 9, 10 with no loss.
- **rd=0 drop.** MEM push rd=0, data=0xFFFFFFFF → `mem_ok_o` stays 1, no `res_v` ever, FIFO count stays 0.
- **Reset mid-operation.** Both FIFOs full and `res_v`=1; assert `rst_n`=0 mid-cycle → `res_v` falls immediately. After release, `ok_o`=1 on both channels and no stale write is issued.
